// File: rtl/alu_serial.sv
// Multi-cycle 74181-style ALU: processes one SLICE-bit slice per clock, LSB first,
// with an internal ripple carry, a valid/ready handshake and held registered results.
module alu_serial #(
    parameter int WIDTH = 16,
    parameter int SLICE = 4
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             valid_i,
    output logic             ready_o,
    input  logic             mode_control_i,
    input  logic [3:0]       select_input_i,
    input  logic [WIDTH-1:0] operand_a_i,
    input  logic [WIDTH-1:0] operand_b_i,
    input  logic             carry_input_i,
    output logic             valid_o,
    input  logic             ready_i,
    output logic [WIDTH-1:0] function_output_o,
    output logic             carry_output_o,
    output logic             cmp_output_o,
    output logic             overflow_o
);

    localparam int NSLICE = WIDTH / SLICE;
    localparam int CNT_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NSLICE - 1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    // Bitwise logic-mode function of one slice.
    function automatic logic [SLICE-1:0] slice_logic(
        input logic [SLICE-1:0] a,
        input logic [SLICE-1:0] b,
        input logic [3:0]       s
    );
        logic [SLICE-1:0] f;
        case (s)
            4'd0:    f = ~a;
            4'd1:    f = ~(a | b);
            4'd2:    f = ~a & b;
            4'd3:    f = {SLICE{1'b0}};
            4'd4:    f = ~(a & b);
            4'd5:    f = ~b;
            4'd6:    f = a ^ b;
            4'd7:    f = a & ~b;
            4'd8:    f = ~a | b;
            4'd9:    f = ~(a ^ b);
            4'd10:   f = b;
            4'd11:   f = a & b;
            4'd12:   f = {SLICE{1'b1}};
            4'd13:   f = a | ~b;
            4'd14:   f = a | b;
            4'd15:   f = a;
            default: f = {SLICE{1'b0}};
        endcase
        return f;
    endfunction

    // Arithmetic-mode addends {P, Q} of one slice; F = P + Q + cn.
    function automatic logic [2*SLICE-1:0] slice_pq(
        input logic [SLICE-1:0] a,
        input logic [SLICE-1:0] b,
        input logic [3:0]       s
    );
        logic [SLICE-1:0] p;
        logic [SLICE-1:0] q;
        case (s)
            4'd0:    begin p = a;              q = {SLICE{1'b0}}; end
            4'd1:    begin p = a | b;          q = {SLICE{1'b0}}; end
            4'd2:    begin p = a | ~b;         q = {SLICE{1'b0}}; end
            4'd3:    begin p = {SLICE{1'b0}};  q = {SLICE{1'b1}}; end
            4'd4:    begin p = a;              q = a & ~b;        end
            4'd5:    begin p = a | b;          q = a & ~b;        end
            4'd6:    begin p = a;              q = ~b;            end
            4'd7:    begin p = a & ~b;         q = {SLICE{1'b1}}; end
            4'd8:    begin p = a;              q = a & b;         end
            4'd9:    begin p = a;              q = b;             end
            4'd10:   begin p = a | ~b;         q = a & b;         end
            4'd11:   begin p = a & b;          q = {SLICE{1'b1}}; end
            4'd12:   begin p = a;              q = a;             end
            4'd13:   begin p = a | b;          q = a;             end
            4'd14:   begin p = a | ~b;         q = a;             end
            4'd15:   begin p = a;              q = {SLICE{1'b1}}; end
            default: begin p = {SLICE{1'b0}};  q = {SLICE{1'b0}}; end
        endcase
        return {p, q};
    endfunction

    logic [1:0]       state_r;
    logic [CNT_W-1:0] cnt_r;
    logic             carry_r;
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    logic             m_r;
    logic [3:0]       s_r;
    logic [WIDTH-1:0] f_work_r;

    logic [WIDTH-1:0] f_out_r;
    logic             cout_r;
    logic             cmp_r;
    logic             ovf_r;
    logic             valid_r;
    logic             ready_r;

    logic [SLICE-1:0] a_sl_s;
    logic [SLICE-1:0] b_sl_s;
    logic [SLICE-1:0] p_s;
    logic [SLICE-1:0] q_s;
    logic [SLICE:0]   sum_s;
    logic             c_msb_s;
    logic [SLICE-1:0] slice_f_s;
    logic [WIDTH-1:0] next_work_s;
    logic             last_s;

    // Current slice: operand extraction, slice result and merge into the partial word.
    always_comb begin
        a_sl_s      = a_r[int'(cnt_r) * SLICE +: SLICE];
        b_sl_s      = b_r[int'(cnt_r) * SLICE +: SLICE];
        {p_s, q_s}  = slice_pq(a_sl_s, b_sl_s, s_r);
        sum_s       = {1'b0, p_s} + {1'b0, q_s} + {{SLICE{1'b0}}, carry_r};
        // Carry into the slice MSB recovered from the MSB sum bit.
        c_msb_s     = sum_s[SLICE-1] ^ p_s[SLICE-1] ^ q_s[SLICE-1];
        if (m_r) begin
            slice_f_s = slice_logic(a_sl_s, b_sl_s, s_r);
        end else begin
            slice_f_s = sum_s[SLICE-1:0];
        end
        next_work_s = f_work_r;
        next_work_s[int'(cnt_r) * SLICE +: SLICE] = slice_f_s;
        last_s      = (cnt_r == LAST_CNT);
    end

    // Handshake FSM, slice iteration and result registers.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_r  <= ST_IDLE;
            cnt_r    <= {CNT_W{1'b0}};
            carry_r  <= 1'b0;
            a_r      <= {WIDTH{1'b0}};
            b_r      <= {WIDTH{1'b0}};
            m_r      <= 1'b0;
            s_r      <= 4'd0;
            f_work_r <= {WIDTH{1'b0}};
            f_out_r  <= {WIDTH{1'b0}};
            cout_r   <= 1'b1;
            cmp_r    <= 1'b0;
            ovf_r    <= 1'b0;
            valid_r  <= 1'b0;
            ready_r  <= 1'b1;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (valid_i) begin
                        a_r      <= operand_a_i;
                        b_r      <= operand_b_i;
                        m_r      <= mode_control_i;
                        s_r      <= select_input_i;
                        carry_r  <= ~carry_input_i;
                        cnt_r    <= {CNT_W{1'b0}};
                        f_work_r <= {WIDTH{1'b0}};
                        state_r  <= ST_RUN;
                        ready_r  <= 1'b0;
                    end
                end
                ST_RUN: begin
                    f_work_r <= next_work_s;
                    carry_r  <= sum_s[SLICE];
                    cnt_r    <= cnt_r + CNT_W'(1);
                    if (last_s) begin
                        state_r <= ST_DONE;
                        valid_r <= 1'b1;
                        f_out_r <= next_work_s;
                        cmp_r   <= &next_work_s;
                        if (m_r) begin
                            cout_r <= 1'b1;
                            ovf_r  <= 1'b0;
                        end else begin
                            cout_r <= ~sum_s[SLICE];
                            ovf_r  <= c_msb_s ^ sum_s[SLICE];
                        end
                    end
                end
                ST_DONE: begin
                    if (ready_i) begin
                        state_r <= ST_IDLE;
                        valid_r <= 1'b0;
                        ready_r <= 1'b1;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    valid_r <= 1'b0;
                    ready_r <= 1'b1;
                end
            endcase
        end
    end

    assign ready_o           = ready_r;
    assign valid_o           = valid_r;
    assign function_output_o = f_out_r;
    assign carry_output_o    = cout_r;
    assign cmp_output_o      = cmp_r;
    assign overflow_o        = ovf_r;

endmodule

// File: doc/alu_serial.md
Name: alu_serial

Overview:
- Parametrised, multi-cycle successor to the 4-bit 74181-style ALU.
- Computes the same 32 functions (16 logic, 16 arithmetic) on WIDTH-bit operands by iterating one SLICE-bit slice per clock, LSB first, with an internal ripple carry.
- Adds a valid/ready handshake, an overflow flag and a held, registered result.
- Sits between the datapath operand registers and the result bus wherever area beats latency.

Parameters:
- WIDTH, 16, operand/result width; must be a multiple of SLICE.
- SLICE, 4, bits processed per cycle; NSLICE = WIDTH/SLICE; NSLICE >= 1.

Ports:
- clk_i  input  1  clock; all logic on the rising edge.
- rst_n_i  input  1  synchronous, active-low reset.
- valid_i  input  1  request valid.
- ready_o  output  1  block accepts a request.
- mode_control_i  input  1  1 = logic, 0 = arithmetic.
- select_input_i  input  4  function select S.
- operand_a_i  input  WIDTH  operand A.
- operand_b_i  input  WIDTH  operand B.
- carry_input_i  input  1  active-low carry in; cn = ~carry_input_i.
- valid_o  output  1  result valid.
- ready_i  input  1  consumer accepts result.
- function_output_o  output  WIDTH  result F.
- carry_output_o  output  1  active-low carry out of the MSB.
- cmp_output_o  output  1  1 when F is all ones.
- overflow_o  output  1  signed overflow.

Behaviour:
- Reset (rst_n_i=0 at an edge):
  - State goes to IDLE; slice counter and carry are cleared.
  - Outputs: valid_o=0, ready_o=1, function_output_o=0, carry_output_o=1, cmp_output_o=0, overflow_o=0.
  - Reset has priority over everything, including an in-flight RUN; any partial result is discarded.
- FSM IDLE -> RUN -> DONE -> IDLE:
  - ready_o=1 only in IDLE.
- IDLE:
  - On valid_i=1, the request is accepted at that edge.
  - A, B, M, S and cn are captured; carry is set to cn; counter = 0; state goes to RUN.
  - valid_i is ignored in every other state.
- RUN:
  - Each edge computes slice k = counter and writes F[k*SLICE +: SLICE].
  - Counter and carry advance.
  - After the edge that processes slice NSLICE-1, state goes to DONE.
  - valid_o rises exactly NSLICE cycles after the accept edge. Input changes during RUN have no effect.
- DONE:
  - valid_o=1; all result outputs are held stable.
  - On ready_i=1, state returns to IDLE at that edge; valid_o=0 and ready_o=1 from the next cycle.
  - Minimum issue interval is NSLICE+2 cycles.
- Logic mode (M=1), bitwise, by S = 0..15:
  - ~A, ~(A|B), ~A&B, 0, ~(A&B), ~B, A^B, A&~B, ~A|B, ~(A^B), B, A&B, all-ones, A|~B, A|B, A.
  - carry_output_o=1, overflow_o=0.
- Arithmetic mode (M=0): F = P + Q + cn modulo 2^WIDTH. P/Q by S = 0..15:
  - 0: A/0
  - 1: (A|B)/0
  - 2: (A|~B)/0
  - 3: 0/all-ones
  - 4: A/(A&~B)
  - 5: (A|B)/(A&~B)
  - 6: A/~B
  - 7: (A&~B)/all-ones
  - 8: A/(A&B)
  - 9: A/B
  - 10: (A|~B)/(A&B)
  - 11: (A&B)/all-ones
  - 12: A/A
  - 13: (A|B)/A
  - 14: (A|~B)/A
  - 15: A/all-ones
- Arithmetic flags:
  - carry_output_o = ~(carry out of bit WIDTH-1).
  - overflow_o = carry into MSB XOR carry out of MSB.
- cmp_output_o = &F in both modes. With M=0, S=0110, cn=0 it flags A==B.
- Outputs change only on the RUN->DONE edge and on reset.

Test Plan (WIDTH=16, SLICE=4):
1. Add: M=0, S=1001, A=0x1234, B=0x0FFF, carry_input_i=1 -> F=0x2233, carry_output_o=1, overflow_o=0. valid_o rises exactly 4 cycles after the accept edge; ready_o=0 throughout.
2. Compare: M=0, S=0110, A=B=0x0005, carry_input_i=1 -> F=0xFFFF, cmp_output_o=1, carry_output_o=1. Repeat with carry_input_i=0 -> F=0x0000, cmp_output_o=0, carry_output_o=0.
3. Wrap/overflow, M=0, S=1001, carry_input_i=1:
   - A=0xFFFF, B=0x0001 -> F=0x0000, carry_output_o=0, overflow_o=0.
   - A=0x7FFF, B=0x0001 -> F=0x8000, carry_output_o=1, overflow_o=1.
   - With carry_input_i=0, A=0x00FF, B=0x0000 -> F=0x0100 (carry crosses slices).
4. Logic: M=1, A=0xF0F0, B=0xFF00:
   - S=0110 -> 0x0FF0.
   - S=0011 -> 0x0000.
   - S=1100 -> 0xFFFF, cmp_output_o=1.
   - In all cases carry_output_o=1, overflow_o=0.
5. Backpressure: hold ready_i=0 for 3 cycles in DONE while driving a new valid_i and toggling operands -> outputs stable, ready_o=0, no capture. Raise ready_i -> ready_o=1 the next cycle; the second op is accepted and computed correctly.
6. Reset mid-RUN: assert rst_n_i=0 one edge after accept -> next cycle valid_o=0, ready_o=1, F=0, carry_output_o=1. A following op (S=1001, 0x0001+0x0001, carry_input_i=1) gives F=0x0002.
